// File: rtl/bt_drive_sequencer_if.sv
// Receive-path and motor-driver signal bundle for bt_drive_sequencer.
// master = command source / motor consumer, slave = the sequencer.
interface bt_drive_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [5:0] bump;
    logic       motorL_en;
    logic       motorR_en;
    logic       motorL_dir;
    logic       motorR_dir;
    logic       motorL_pwm;
    logic       motorR_pwm;
    logic       busy;
    logic [1:0] state_out;
    logic       fault;

    modport master (
        output rx_valid, rx_data, bump,
        input  motorL_en, motorR_en, motorL_dir, motorR_dir,
               motorL_pwm, motorR_pwm, busy, state_out, fault
    );

    modport slave (
        input  rx_valid, rx_data, bump,
        output motorL_en, motorR_en, motorL_dir, motorR_dir,
               motorL_pwm, motorR_pwm, busy, state_out, fault
    );
endinterface

// File: rtl/bt_drive_sequencer.sv
// Bluetooth drive-command sequencer: timed RUN, BRAKE, sticky bumper fault, shared PWM.
// Optional macro SPEED_CMD_EN: ASCII digits '0'..'9' set PWM duty to digit*28.
module bt_drive_sequencer #(
    parameter int unsigned RUN_TICKS    = 16000000,
    parameter int unsigned BRAKE_TICKS  = 1600000,
    parameter logic [7:0]  DEFAULT_DUTY = 8'd128
) (
    input logic                  WF_CLK,
    input logic                  reset,
    bt_drive_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        BRAKE = 2'b10
    } state_t;

    localparam logic [31:0] RUN_LOAD   = 32'(RUN_TICKS - 1);
    localparam logic [31:0] BRAKE_LOAD = 32'(BRAKE_TICKS - 1);

    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;

`ifdef SPEED_CMD_EN
    function automatic logic [7:0] digit_duty(input logic [7:0] b);
        // Only called for 0x30..0x39, so the low nibble is the digit itself.
        return {4'd0, b[3:0]} * 8'd28;
    endfunction
`endif

    state_t      state, state_nx;
    logic [31:0] timer, timer_nx;
    logic [7:0]  pwm_cnt, pwm_cnt_nx;
    logic [7:0]  duty, duty_nx;
    logic        en, en_nx;
    logic        dir_l, dir_l_nx;
    logic        dir_r, dir_r_nx;
    logic        pwm, pwm_nx;
    logic        busy, busy_nx;
    logic        fault, fault_nx;

    logic bump_any;
    logic is_motion;
    logic accept;
    logic stop_cmd;
    logic clear_cmd;

    assign bump_any  = |bus.bump;
    assign is_motion = bus.rx_valid &&
                       (bus.rx_data == CMD_F || bus.rx_data == CMD_B ||
                        bus.rx_data == CMD_L || bus.rx_data == CMD_R);
    assign accept    = is_motion && !fault && !bump_any;
    assign stop_cmd  = bus.rx_valid && (bus.rx_data == CMD_S);
    assign clear_cmd = bus.rx_valid && (bus.rx_data == CMD_C);

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        en_nx      = en;
        dir_l_nx   = dir_l;
        dir_r_nx   = dir_r;
        duty_nx    = duty;
        pwm_cnt_nx = pwm_cnt + 8'd1;
        // A bump in the same cycle as 'C' keeps the fault set.
        fault_nx   = bump_any ? 1'b1 : (clear_cmd ? 1'b0 : fault);

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                    en_nx    = 1'b1;
                    dir_l_nx = (bus.rx_data == CMD_F) || (bus.rx_data == CMD_R);
                    dir_r_nx = (bus.rx_data == CMD_F) || (bus.rx_data == CMD_L);
                    timer_nx = RUN_LOAD;
                end
            end
            RUN: begin
                // accept already excludes bump, so a retrigger beats only timer expiry.
                if (accept) begin
                    dir_l_nx = (bus.rx_data == CMD_F) || (bus.rx_data == CMD_R);
                    dir_r_nx = (bus.rx_data == CMD_F) || (bus.rx_data == CMD_L);
                    timer_nx = RUN_LOAD;
                end else if (bump_any || stop_cmd || timer == 32'd0) begin
                    state_nx = BRAKE;
                    en_nx    = 1'b0;
                    timer_nx = BRAKE_LOAD;
                end else begin
                    timer_nx = timer - 32'd1;
                end
            end
            BRAKE: begin
                if (timer == 32'd0) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 32'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                en_nx    = 1'b0;
                timer_nx = 32'd0;
            end
        endcase

`ifdef SPEED_CMD_EN
        if (bus.rx_valid && bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            duty_nx = digit_duty(bus.rx_data);
        end
`endif

        pwm_nx  = en_nx && (pwm_cnt_nx < duty_nx);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge WF_CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= 32'd0;
            pwm_cnt <= 8'd0;
            duty    <= DEFAULT_DUTY;
            en      <= 1'b0;
            dir_l   <= 1'b0;
            dir_r   <= 1'b0;
            pwm     <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pwm_cnt <= pwm_cnt_nx;
            duty    <= duty_nx;
            en      <= en_nx;
            dir_l   <= dir_l_nx;
            dir_r   <= dir_r_nx;
            pwm     <= pwm_nx;
            busy    <= busy_nx;
            fault   <= fault_nx;
        end
    end

    assign bus.motorL_en  = en;
    assign bus.motorR_en  = en;
    assign bus.motorL_dir = dir_l;
    assign bus.motorR_dir = dir_r;
    assign bus.motorL_pwm = pwm;
    assign bus.motorR_pwm = pwm;
    assign bus.busy       = busy;
    assign bus.state_out  = state;
    assign bus.fault      = fault;

endmodule

// File: doc/bt_drive_sequencer.md
Name: bt_drive_sequencer

Overview:
- Command sequencer between the Bluetooth receive path (received byte plus one-cycle valid strobe) and the two motor drivers.
- Decodes single-byte ASCII drive commands and runs each motion for a fixed timed interval, followed by a brake interval.
- Aborts and latches a fault on any bumper contact.
- Generates motor enable, direction and PWM outputs for the top level.

Parameters:
- RUN_TICKS, 16000000, clock cycles a motion command drives the motors (1 s at 16 MHz).
- BRAKE_TICKS, 1600000, clock cycles in BRAKE before returning to IDLE (100 ms).
- DEFAULT_DUTY, 128, 8-bit PWM duty loaded at reset.

Ports:
- WF_CLK  in  1  system clock, 16 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- bump  in  6  bumper switches; any bit high means contact.
- motorL_en, motorR_en  out  1  motor driver enables.
- motorL_dir, motorR_dir  out  1  direction; 1 = forward.
- motorL_pwm, motorR_pwm  out  1  PWM drive.
- busy  out  1  high when state is not IDLE.
- state_out  out  2  IDLE=00, RUN=01, BRAKE=10.
- fault  out  1  sticky collision flag.

Behaviour:
- All outputs registered.
- Reset values:
  - state IDLE; timer 0; pwm_cnt 0; duty=DEFAULT_DUTY.
  - All en/dir/pwm outputs 0; busy 0; fault 0.
  - Reset asserted mid-operation forces these values immediately (asynchronous).
- Commands are bytes with rx_valid=1; all other bytes are ignored (no state change):
  - 'F' 0x46: L=1, R=1.
  - 'B' 0x42: L=0, R=0.
  - 'L' 0x4C: L=0, R=1.
  - 'R' 0x52: L=1, R=0.
  - 'S' 0x53: stop.
  - 'C' 0x43: clear fault.
- Motion commands are F/B/L/R. They are accepted only when fault=0 and bump==0 in that cycle.
- IDLE:
  - Accepted motion command at cycle N: at N+1 state=RUN, en=1 on both motors, dirs latched, timer=RUN_TICKS-1.
- RUN:
  - timer decrements each cycle.
  - timer==0 -> BRAKE.
  - New accepted motion command -> dirs updated, timer reloaded to RUN_TICKS-1, stay in RUN (retrigger).
  - 'S' -> BRAKE.
- BRAKE:
  - On entry: en=0, pwm=0, dirs hold last value, timer=BRAKE_TICKS-1.
  - Decrements to 0, then -> IDLE.
  - Motion commands and 'S' are ignored.
- Bump:
  - Sampled every cycle in every state.
  - Any bit high sets fault=1 next cycle.
  - In RUN, a bump forces BRAKE next cycle.
- 'C' clears fault only if bump==0 in the same cycle. Accepted in any state.
- Simultaneous events:
  - Bump and motion command in the same cycle: bump wins (BRAKE, fault=1).
  - Bump and 'C' in the same cycle: fault stays 1.
  - timer==0 and an accepted motion command in the same cycle in RUN: retrigger wins.
- PWM:
  - 8-bit pwm_cnt free-runs in all states and wraps 255->0.
  - pwm = en & (pwm_cnt < duty), applied to both motors.
  - duty=0 gives pwm constantly 0.
- busy = (state != IDLE).
- Timer width is 32 bits. RUN_TICKS and BRAKE_TICKS must be >= 1.

Optional Feature:
- Macro SPEED_CMD_EN.
- Defined:
  - Bytes '0'..'9' (0x30..0x39) set duty = digit*28 (0..252), effective the next cycle.
  - Accepted in any state, including while fault=1.
  - duty persists until the next digit or reset.
- Undefined:
  - Digits are ignored; duty stays at DEFAULT_DUTY.

Test Plan:
1. All scenarios use RUN_TICKS=20, BRAKE_TICKS=5. Reset, then send 'F' -> next cycle state_out=01, both en=1, both dir=1; 20 cycles in RUN, then 5 cycles in BRAKE (en=0), then IDLE with busy=0.
2. 'L', then 'R' 10 cycles later -> dirs change to L=1, R=0; RUN lasts 20 cycles after the 'R'; state never leaves RUN in between.
3. bump[3] pulsed for one cycle in RUN -> next cycle BRAKE, fault=1; 'F' after return to IDLE ignored; 'C' with bump=0 -> fault=0; 'F' then enters RUN.
4. 'S' in RUN -> BRAKE next cycle; 'F' sent during BRAKE ignored; IDLE after 5 cycles.
5. PWM over 256 consecutive RUN cycles:
   - DEFAULT_DUTY=128 -> exactly 128 high cycles.
   - With SPEED_CMD_EN, '9' -> 252 high cycles.
   - With SPEED_CMD_EN, '0' -> 0 high cycles.
6. 'x' (0x78) in IDLE -> no output change; reset asserted mid-RUN -> en, pwm, dir, busy and fault all 0 without waiting for a clock edge.
